// File: rtl/gray_matrix_3x3.sv
//------------------------------------------------------------------------------
// Module      : gray_matrix_3x3
// Description : Builds a 3x3 gray-pixel window from the raster stream using two
//               line buffers, with in-block border handling.
//               Optional feature macro: MATRIX_EDGE_REPLICATE_EN
//               (defined: border replication, undefined: zero padding).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_matrix_3x3 #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    output logic       matrix_frame_vsync,
    output logic       matrix_frame_href,
    output logic       matrix_frame_clken,
    output logic [7:0] matrix_p11,
    output logic [7:0] matrix_p12,
    output logic [7:0] matrix_p13,
    output logic [7:0] matrix_p21,
    output logic [7:0] matrix_p22,
    output logic [7:0] matrix_p23,
    output logic [7:0] matrix_p31,
    output logic [7:0] matrix_p32,
    output logic [7:0] matrix_p33
);

    localparam int c_col_w = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int c_row_w = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_HDISP - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_VDISP - 1);

    logic               w_accept;
    logic               w_take;
    logic               w_href_fall;
    logic               w_vsync_rise;

    logic               r_href_d;
    logic               r_vsync_d;
    logic               r_line_full;
    logic               r_line_any;
    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;

    logic [7:0]         r_lb1 [IMG_HDISP];
    logic [7:0]         r_lb2 [IMG_HDISP];

    logic               r_s1_take;
    logic               r_s1_vsync;
    logic               r_s1_href;
    logic [7:0]         r_s1_pix;
    logic [7:0]         r_s1_lb1;
    logic [7:0]         r_s1_lb2;
    logic [c_col_w-1:0] r_s1_col;
    logic [c_row_w-1:0] r_s1_row;

    // [row][column], index 0 = row 1 / column 1 (oldest)
    logic [7:0]         r_raw [3][3];
    logic [7:0]         r_win [3][3];
    logic [7:0]         w_raw [3][3];
    logic [7:0]         w_rowf [3][3];
    logic [7:0]         w_win [3][3];
    logic               r_s2_vsync;
    logic               r_s2_href;
    logic               r_s2_take;

    assign w_accept     = per_frame_href & per_frame_clken;
    assign w_take       = w_accept & ~r_line_full;
    assign w_href_fall  = r_href_d & ~per_frame_href;
    assign w_vsync_rise = per_frame_vsync & ~r_vsync_d;

    // Position counters; r_line_full marks that the last column was taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_href_d    <= 1'b0;
            r_vsync_d   <= 1'b0;
            r_line_full <= 1'b0;
            r_line_any  <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
        end else begin
            r_href_d  <= per_frame_href;
            r_vsync_d <= per_frame_vsync;
            if (w_vsync_rise) begin
                r_line_full <= 1'b0;
                r_line_any  <= 1'b0;
                r_col       <= '0;
                r_row       <= '0;
            end else if (w_href_fall) begin
                r_line_full <= 1'b0;
                r_line_any  <= 1'b0;
                r_col       <= '0;
                if (r_line_any && (r_row != c_row_last)) begin
                    r_row <= r_row + 1'b1;
                end
            end else if (w_take) begin
                r_line_any <= 1'b1;
                if (r_col == c_col_last) begin
                    r_line_full <= 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Line buffer storage carries no reset; stale words are masked by row.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_lb1[r_col] <= per_img_Y;
            r_lb2[r_col] <= r_lb1[r_col];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_take  <= 1'b0;
            r_s1_vsync <= 1'b0;
            r_s1_href  <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_lb1   <= '0;
            r_s1_lb2   <= '0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
        end else begin
            r_s1_take  <= w_take;
            r_s1_vsync <= per_frame_vsync;
            r_s1_href  <= per_frame_href;
            r_s1_pix   <= per_img_Y;
            r_s1_lb1   <= r_lb1[r_col];
            r_s1_lb2   <= r_lb2[r_col];
            r_s1_col   <= r_col;
            r_s1_row   <= r_row;
        end
    end

    // Shift the unmasked window, then derive the border-handled view from it.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_raw[r][0] = r_raw[r][1];
            w_raw[r][1] = r_raw[r][2];
        end
        w_raw[0][2] = r_s1_lb2;
        w_raw[1][2] = r_s1_lb1;
        w_raw[2][2] = r_s1_pix;

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_rowf[r][c] = w_raw[r][c];
                w_win[r][c]  = w_raw[r][c];
            end
        end

`ifdef MATRIX_EDGE_REPLICATE_EN
        for (int c = 0; c < 3; c++) begin
            w_rowf[2][c] = w_raw[2][c];
            w_rowf[1][c] = (r_s1_row != '0) ? w_raw[1][c] : w_raw[2][c];
            w_rowf[0][c] = (r_s1_row > c_row_w'(1)) ? w_raw[0][c] : w_rowf[1][c];
        end
        for (int r = 0; r < 3; r++) begin
            w_win[r][2] = w_rowf[r][2];
            w_win[r][1] = (r_s1_col != '0) ? w_rowf[r][1] : w_rowf[r][2];
            w_win[r][0] = (r_s1_col > c_col_w'(1)) ? w_rowf[r][0] : w_win[r][1];
        end
`else
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (((r == 0) && !(r_s1_row > c_row_w'(1))) ||
                    ((r == 1) && (r_s1_row == '0)) ||
                    ((c == 0) && !(r_s1_col > c_col_w'(1))) ||
                    ((c == 1) && (r_s1_col == '0))) begin
                    w_win[r][c] = 8'd0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vsync <= 1'b0;
            r_s2_href  <= 1'b0;
            r_s2_take  <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_raw[r][c] <= '0;
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_s2_vsync <= r_s1_vsync;
            r_s2_href  <= r_s1_href;
            r_s2_take  <= r_s1_take;
            if (r_s1_take) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        r_raw[r][c] <= w_raw[r][c];
                        r_win[r][c] <= w_win[r][c];
                    end
                end
            end
        end
    end

    assign matrix_frame_vsync = r_s2_vsync;
    assign matrix_frame_href  = r_s2_href;
    assign matrix_frame_clken = r_s2_take;
    assign matrix_p11 = r_win[0][0];
    assign matrix_p12 = r_win[0][1];
    assign matrix_p13 = r_win[0][2];
    assign matrix_p21 = r_win[1][0];
    assign matrix_p22 = r_win[1][1];
    assign matrix_p23 = r_win[1][2];
    assign matrix_p31 = r_win[2][0];
    assign matrix_p32 = r_win[2][1];
    assign matrix_p33 = r_win[2][2];

endmodule

`default_nettype wire

// File: tb/tb_gray_matrix_3x3.sv
//------------------------------------------------------------------------------
// Module      : tb_gray_matrix_3x3
// Description : Self-checking bench for gray_matrix_3x3 against a frame-level
//               reference model (honours MATRIX_EDGE_REPLICATE_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gray_matrix_3x3;

    localparam int H = 4;
    localparam int V = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] per_img_Y;
    logic       matrix_frame_vsync;
    logic       matrix_frame_href;
    logic       matrix_frame_clken;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;

    gray_matrix_3x3 #(
        .IMG_HDISP (H),
        .IMG_VDISP (V)
    ) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .per_frame_vsync    (per_frame_vsync),
        .per_frame_href     (per_frame_href),
        .per_frame_clken    (per_frame_clken),
        .per_img_Y          (per_img_Y),
        .matrix_frame_vsync (matrix_frame_vsync),
        .matrix_frame_href  (matrix_frame_href),
        .matrix_frame_clken (matrix_frame_clken),
        .matrix_p11         (matrix_p11),
        .matrix_p12         (matrix_p12),
        .matrix_p13         (matrix_p13),
        .matrix_p21         (matrix_p21),
        .matrix_p22         (matrix_p22),
        .matrix_p23         (matrix_p23),
        .matrix_p31         (matrix_p31),
        .matrix_p32         (matrix_p32),
        .matrix_p33         (matrix_p33)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    string c_names [9] = '{"p11", "p12", "p13", "p21", "p22", "p23", "p31", "p32", "p33"};

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 60)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: frame memory indexed by line, window read by coordinates.
    logic [7:0] m_lines [4][H];
    logic [7:0] m_win [9];
    int         m_col, m_row, m_lidx;
    bit         m_full, m_any, m_hp, m_vp;
    int         m_acc_cnt = 0;
    int         dut_pulses = 0;
    logic       n_vs, n_hr, n_ce, e_vs, e_hr, e_ce;
    logic [7:0] e_win [9];

    task automatic model_reset();
        m_col = 0; m_row = 0; m_lidx = 0;
        m_full = 0; m_any = 0; m_hp = 0; m_vp = 0;
        n_vs = 0; n_hr = 0; n_ce = 0;
        e_vs = 0; e_hr = 0; e_ce = 0;
        for (int k = 0; k < 9; k++) begin
            m_win[k] = 8'd0;
            e_win[k] = 8'd0;
        end
    endtask

    task automatic model_step(input logic vs, input logic hr, input logic ce, input logic [7:0] y);
        bit eff;
        int rv, cv, ri, cj;
        eff = hr && ce && !m_full;
        if (eff) begin
            m_lines[m_lidx % 4][m_col] = y;
            rv = (m_row < 2) ? 2 - m_row : 0;
            cv = (m_col < 2) ? 2 - m_col : 0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
`ifdef MATRIX_EDGE_REPLICATE_EN
                    ri = (i < rv) ? rv : i;
                    cj = (j < cv) ? cv : j;
                    m_win[i*3+j] = m_lines[(m_lidx + 2 + ri) % 4][m_col - 2 + cj];
`else
                    ri = i;
                    cj = j;
                    if (i >= rv && j >= cv)
                        m_win[i*3+j] = m_lines[(m_lidx + 2 + ri) % 4][m_col - 2 + cj];
                    else
                        m_win[i*3+j] = 8'd0;
`endif
                end
            end
            if (m_col == H - 1) m_full = 1;
            else m_col++;
            m_any = 1;
            m_acc_cnt++;
        end
        if (m_hp && !hr) begin
            if (m_any) begin
                if (m_row < V - 1) m_row++;
                m_lidx++;
            end
            m_col = 0; m_full = 0; m_any = 0;
        end
        if (vs && !m_vp) begin
            m_col = 0; m_row = 0; m_lidx = 0; m_full = 0; m_any = 0;
        end
        m_hp = hr;
        m_vp = vs;
        n_vs = vs;
        n_hr = hr;
        n_ce = eff;
    endtask

    // One clock: drive inputs, advance model, check outputs due this cycle.
    task automatic tick(input logic vs, input logic hr, input logic ce, input logic [7:0] y);
        logic [7:0] got [9];
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ce;
        per_img_Y       = y;
        if (rst_n) model_step(vs, hr, ce, y);
        @(posedge clk);
        #1;
        got = '{matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
                matrix_p23, matrix_p31, matrix_p32, matrix_p33};
        check_value("vsync_out", matrix_frame_vsync, e_vs);
        check_value("href_out", matrix_frame_href, e_hr);
        check_value("clken_out", matrix_frame_clken, e_ce);
        for (int k = 0; k < 9; k++) check_value(c_names[k], got[k], e_win[k]);
        if (matrix_frame_clken) dut_pulses++;
        e_vs = n_vs;
        e_hr = n_hr;
        e_ce = n_ce;
        for (int k = 0; k < 9; k++) e_win[k] = m_win[k];
    endtask

    task automatic reset_cycles(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < n; k++)
            tick(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        per_frame_vsync = 0; per_frame_href = 0; per_frame_clken = 0; per_img_Y = 0;
        rst_n = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    task automatic vsync_pulse();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    // Independent literal expectations for the 4x4 frame of pixels 1..16.
    task automatic spot(input int pix);
        logic [7:0] got [9];
        logic [7:0] exp [9];
`ifdef MATRIX_EDGE_REPLICATE_EN
        case (pix)
            1:       exp = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
            6:       exp = '{1, 1, 2, 1, 1, 2, 5, 5, 6};
            default: exp = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        endcase
`else
        case (pix)
            1:       exp = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
            6:       exp = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
            default: exp = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        endcase
`endif
        got = '{matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
                matrix_p23, matrix_p31, matrix_p32, matrix_p33};
        for (int k = 0; k < 9; k++)
            check_value($sformatf("spot%0d_%s", pix, c_names[k]), got[k], exp[k]);
    endtask

    task automatic det_frame();
        int prev, v;
        prev = 0;
        vsync_pulse();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = r * 4 + c + 1;
                tick(0, 1, 1, 8'(v));
                if (prev == 1 || prev == 6 || prev == 11) spot(prev);
                prev = v;
            end
            prev = 0;
            for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
        end
    endtask

    // gapmode: 0 full rate, 1 alternating 50% duty, 2 random gaps
    task automatic run_frame(input int nlines, input int npix, input int gapmode, input bit cst);
        vsync_pulse();
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < npix; p++) begin
                if (gapmode == 1 || (gapmode == 2 && ($urandom % 3) == 0))
                    tick(0, 1, 0, 8'($urandom));
                tick(0, 1, 1, cst ? 8'h80 : 8'($urandom));
            end
            for (int k = 0; k < 3; k++) tick(0, 0, 1'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        per_frame_vsync = 0; per_frame_href = 0; per_frame_clken = 0; per_img_Y = 0;
        rst_n = 1'b0;
        reset_cycles(6);
        det_frame();
        run_frame(4, H, 1, 0);
        run_frame(7, H, 2, 0);
        run_frame(3, H + 3, 0, 0);
        // Partial frame, then reset in the middle of a line.
        vsync_pulse();
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < H; p++) tick(0, 1, 1, 8'($urandom));
            for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
        end
        tick(0, 1, 1, 8'($urandom));
        tick(0, 1, 1, 8'($urandom));
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        reset_cycles(3);
        run_frame(3, H, 2, 1);
        for (int k = 0; k < 4; k++) tick(0, 0, 0, 0);
        check_value("clken_pulse_count", dut_pulses, m_acc_cnt);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
